fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Instruction-fetch controller for the 16-bit RISC pipeline.
- Owns the PC and a small direct-mapped, one-word-per-line instruction cache (tag/valid/data arrays).
- Drives the hit/instruction/address inputs of the IF/ID pipeline register; out_hit=0 makes IF/ID hold its contents.
- Sequences miss refills from slow instruction memory over a req/ack handshake, and handles hazard stalls and branch redirects.

Parameters:
INDEX_W, 3, cache index bits (2**INDEX_W lines, one 16-bit word each)
RESET_PC, 16'h0000, PC value after reset
NOP_INSTR, 16'h0000, bubble instruction injected on a branch redirect

Ports:
inp_clk  in  1  clock; all state updates on posedge (IF/ID samples on negedge, so outputs are stable half a cycle earlier)
inp_reset_n  in  1  asynchronous active-low reset
inp_stall  in  1  hazard-unit stall: hold PC, no new fetch delivered
inp_branch_taken  in  1  redirect request from a later stage
inp_branch_target  in  16  redirect word address
inp_invalidate  in  1  clear all valid bits
inp_mem_ack  in  1  memory has data for out_mem_addr (single-cycle pulse)
inp_mem_data  in  16  refill word, valid when inp_mem_ack=1
out_hit  out  1  to IF/ID load enable
out_instruction  out  16  to IF/ID instruction
out_address  out  16  to IF/ID address (current PC)
out_mem_req  out  1  refill request, level-held until ack
out_mem_addr  out  16  refill word address

Behaviour:
- Reset (asynchronous, active-low; the only reset):
  - pc=RESET_PC, state=RUN, all valid=0, out_mem_req=0, out_mem_addr=0, pending redirect cleared.
  - Hence out_hit=0, out_instruction=NOP_INSTR, out_address=RESET_PC.
  - Reset asserted mid-refill abandons the transaction; a late ack is ignored (state is RUN, req=0).
- Address split: idx=pc[INDEX_W-1:0], tag=pc[15:INDEX_W]. lookup_hit = valid[idx] && tag_mem[idx]==tag (combinational).
- out_address=pc always.
- States: RUN, REFILL.
- RUN outputs, priority order:
  - inp_branch_taken: out_hit=1, out_instruction=NOP_INSTR.
  - else inp_stall: out_hit=0.
  - else lookup_hit: out_hit=1, out_instruction=data[idx].
  - else (miss): out_hit=0.
- RUN posedge transitions, same priority:
  - branch: pc<=inp_branch_target.
  - stall: pc held.
  - hit: pc<=pc+1 (16-bit wrap: FFFF->0000).
  - miss: out_mem_req<=1, out_mem_addr<=pc, state<=REFILL.
- REFILL:
  - out_hit=0, out_instruction=NOP_INSTR, pc held.
  - On ack posedge: data[idx(out_mem_addr)]<=inp_mem_data, tag/valid set, out_mem_req<=0, state<=RUN.
  - Next RUN cycle hits (miss penalty = ack latency + 2 cycles).
- Branch during REFILL:
  - The memory transaction is never aborted.
  - Target latched into a pending-redirect register (last request wins).
  - On ack: line written, pc<=pending target, pending cleared; the first RUN cycle after a redirect outputs a NOP bubble (out_hit=1).
  - Branch in the same cycle as ack: same as above (redirect applied on that edge).
- inp_stall during REFILL: no effect on the refill.
- inp_invalidate:
  - Clears all valid bits at posedge.
  - If it coincides with an ack, the refill write wins for that line.
  - Asserted in REFILL: applies to other lines; the refilled line becomes valid.
- Ack while in RUN: ignored.

Optional Feature:
- Macro: FETCH_CTRL_STATS_EN.
- Defined: adds out_hit_count[15:0] and out_miss_count[15:0], both saturating at FFFF and reset to 0.
  - Hit count increments on each RUN cycle with lookup_hit && !stall && !branch.
  - Miss count increments on each RUN->REFILL transition.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package fetch_pkg:
  - State enum (RUN, REFILL).
  - WORD_W=16 and NOP encoding constant.
- One natural sub-module: icache_array (tag/valid/data storage, async-reset valid bits, combinational read, single write port, invalidate-all).
- FSM, PC and redirect logic stay in fetch_ctrl.

Test Plan:
- Cold start:
  - Stimulus: reset release, memory acks after 3 cycles with 16'hA001 for addr 0.
  - Required: out_mem_req=1 with out_mem_addr=0000; then out_hit=1, out_instruction=A001, out_address=0000.
- Warm hit stream:
  - Stimulus: addrs 0-7 preloaded via refills, loop branch back to 0.
  - Required: out_hit=1 every cycle; PC sequence 0,1,...,7; no out_mem_req.
- Stall:
  - Stimulus: inp_stall high 2 cycles at PC=0005 on a hit.
  - Required: out_hit=0, out_address=0005 held; resumes at 0005 then 0006.
- Branch during refill:
  - Stimulus: miss at 0010, branch to 0040 one cycle later, ack after 4 cycles.
  - Required: line 0010 valid; next PC=0040; one NOP bubble with out_hit=1 on the first RUN cycle.
- Conflict/wrap:
  - Stimulus: PC=FFFF hit.
  - Required: next PC=0000.
  - Stimulus: fetch 0008 after 0000 is cached (same idx, different tag).
  - Required: miss, refill replaces the line; then 0000 misses again.
- Reset mid-refill:
  - Stimulus: assert reset while out_mem_req=1, deassert, then a stale ack arrives.
  - Required: out_mem_req=0, PC=RESET_PC, no array write, cache empty.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] NOP_ENC = 16'h0000;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_REFILL = 1'b1
  } state_e;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped one-word-per-line instruction cache storage: valid bits with
// async reset, tag/data arrays, combinational read, single write, invalidate-all.
module icache_array
  import fetch_pkg::*;
#(
  parameter int INDEX_W = 3,
  localparam int LINES  = 2 ** INDEX_W,
  localparam int TAG_W  = WORD_W - INDEX_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [WORD_W-1:0]  rd_data_o,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [WORD_W-1:0]  wr_data_i,
  input  logic               inval_i
);

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [WORD_W-1:0] data_q [LINES];

  // A refill landing in the same cycle as an invalidate keeps its line valid.
  always_comb begin
    valid_d = valid_q;
    if (inval_i) valid_d = '0;
    if (we_i)    valid_d[wr_idx_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC, cache lookup, miss refill over req/ack, stalls
// and redirects. Define FETCH_CTRL_STATS_EN to add saturating hit/miss counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          INDEX_W   = 3,
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_ENC
) (
  input  logic        inp_clk,
  input  logic        inp_reset_n,
  input  logic        inp_stall,
  input  logic        inp_branch_taken,
  input  logic [15:0] inp_branch_target,
  input  logic        inp_invalidate,
  input  logic        inp_mem_ack,
  input  logic [15:0] inp_mem_data,
  output logic        out_hit,
  output logic [15:0] out_instruction,
  output logic [15:0] out_address,
  output logic        out_mem_req,
  output logic [15:0] out_mem_addr
`ifdef FETCH_CTRL_STATS_EN
  ,
  output logic [15:0] out_hit_count,
  output logic [15:0] out_miss_count
`endif
);

  localparam int TAG_W = WORD_W - INDEX_W;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        mem_req_q, mem_req_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        redir_pend_q, redir_pend_d;
  logic [15:0] redir_tgt_q, redir_tgt_d;
  logic        bubble_q, bubble_d;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [WORD_W-1:0] rd_data;
  logic              lookup_hit;
  logic              refill_done;

  icache_array #(.INDEX_W(INDEX_W)) u_array (
    .clk_i     (inp_clk),
    .rst_ni    (inp_reset_n),
    .rd_idx_i  (pc_q[INDEX_W-1:0]),
    .rd_valid_o(rd_valid),
    .rd_tag_o  (rd_tag),
    .rd_data_o (rd_data),
    .we_i      (refill_done),
    .wr_idx_i  (mem_addr_q[INDEX_W-1:0]),
    .wr_tag_i  (mem_addr_q[15:INDEX_W]),
    .wr_data_i (inp_mem_data),
    .inval_i   (inp_invalidate)
  );

  assign lookup_hit  = rd_valid && (rd_tag == pc_q[15:INDEX_W]);
  assign refill_done = (state_q == ST_REFILL) && inp_mem_ack;

  always_ff @(posedge inp_clk or negedge inp_reset_n) begin
    if (!inp_reset_n) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 16'h0000;
      redir_pend_q <= 1'b0;
      bubble_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      redir_pend_q <= redir_pend_d;
      bubble_q     <= bubble_d;
    end
  end

  // Target is only meaningful while redir_pend_q is set.
  always_ff @(posedge inp_clk) begin
    redir_tgt_q <= redir_tgt_d;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    bubble_d     = bubble_q;
    case (state_q)
      ST_RUN: begin
        if (inp_branch_taken) begin
          pc_d     = inp_branch_target;
          bubble_d = 1'b0;
        end else if (inp_stall) begin
          pc_d = pc_q;
        end else if (bubble_q) begin
          bubble_d = 1'b0;
        end else if (lookup_hit) begin
          pc_d = pc_q + 16'd1;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
          state_d    = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (inp_mem_ack) begin
          mem_req_d    = 1'b0;
          state_d      = ST_RUN;
          redir_pend_d = 1'b0;
          if (inp_branch_taken) begin
            pc_d     = inp_branch_target;
            bubble_d = 1'b1;
          end else if (redir_pend_q) begin
            pc_d     = redir_tgt_q;
            bubble_d = 1'b1;
          end
        end else if (inp_branch_taken) begin
          redir_pend_d = 1'b1;
          redir_tgt_d  = inp_branch_target;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    out_hit         = 1'b0;
    out_instruction = NOP_INSTR;
    if (state_q == ST_RUN) begin
      if (inp_branch_taken) begin
        out_hit = 1'b1;
      end else if (inp_stall) begin
        out_hit = 1'b0;
      end else if (bubble_q) begin
        out_hit = 1'b1;
      end else if (lookup_hit) begin
        out_hit         = 1'b1;
        out_instruction = rd_data;
      end
    end
  end

  assign out_address  = pc_q;
  assign out_mem_req  = mem_req_q;
  assign out_mem_addr = mem_addr_q;

`ifdef FETCH_CTRL_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Bubble cycles deliver no instruction, so they are not counted as hits.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == ST_RUN && !inp_branch_taken && !inp_stall && !bubble_q) begin
      if (lookup_hit) hit_cnt_d  = sat_inc(hit_cnt_q);
      else            miss_cnt_d = sat_inc(miss_cnt_q);
    end
  end

  always_ff @(posedge inp_clk or negedge inp_reset_n) begin
    if (!inp_reset_n) begin
      hit_cnt_q  <= 16'h0000;
      miss_cnt_q <= 16'h0000;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign out_hit_count  = hit_cnt_q;
  assign out_miss_count = miss_cnt_q;
`endif

endmodule
